// File: rtl/common.sv
// Shared types and constants for the register-file writeback path.
// Holds the register-file depth, the default starvation limit and the
// write-request bundle used by both requesters and the write port.
package common;

    localparam int REGISTER_FILE_SIZE      = 32;
    localparam int WB_STARVE_LIMIT_DEFAULT = 4;

    // One write request: enable, destination register and data.
    typedef struct packed {
        logic        en;
        logic [4:0]  id;
        logic [31:0] data;
    } wb_req_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy scoreboard for registers awaiting a multi-cycle result.
// An issue sets busy[id], a secondary handshake clears it, and set wins
// when both hit the same id. Entry 0 (x0) never becomes busy. Hazard
// lookups mask an entry being cleared this cycle, which matches the
// register file's same-cycle write bypass.
module regfile_scoreboard
    import common::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       set_en,
    input  logic [4:0] set_id,
    input  logic       clr_en,
    input  logic [4:0] clr_id,
    input  logic [4:0] rs1_id,
    input  logic [4:0] rs2_id,
    input  logic [4:0] rd_id,
    output logic       rs1_busy,
    output logic       rs2_busy,
    output logic       rd_busy
);

    logic [REGISTER_FILE_SIZE-1:0] busy;
    logic [REGISTER_FILE_SIZE-1:0] busy_next;

    // Next busy vector: clear first so a same-cycle set overrides it.
    always_comb begin
        // NOTE: every variable gets its default before any branch so no path can infer a latch.
        busy_next = busy;
        if (clr_en) begin
            busy_next[clr_id] = 1'b0;
        end
        if (set_en && (set_id != 5'd0)) begin
            busy_next[set_id] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    // Busy register; reset discards every pending entry.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: this is a 32-bit flop vector, not a RAM, so it is cheap and safe to reset; non-blocking assignment keeps it race-free.
        if (!reset_n) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    assign rs1_busy = busy[rs1_id] && !(clr_en && (clr_id == rs1_id));
    assign rs2_busy = busy[rs2_id] && !(clr_en && (clr_id == rs2_id));
    assign rd_busy  = busy[rd_id]  && !(clr_en && (clr_id == rd_id));

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter between the in-order writeback
// (primary) and the multi-cycle unit (secondary, valid/ready).
// The primary normally wins; the secondary wins when the primary is idle
// or, with WB_STARVE_GUARD_EN defined, when it has been refused for
// STARVE_LIMIT consecutive cycles and pipe_hold freezes the pipeline.
// Writes to x0 are granted and handshaken but never enable the port.
module regfile_wb_arbiter
    import common::*;
#(
    parameter int STARVE_LIMIT = WB_STARVE_LIMIT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        pri_en,
    input  logic [4:0]  pri_id,
    input  logic [31:0] pri_data,
    input  logic        sec_valid,
    input  logic [4:0]  sec_id,
    input  logic [31:0] sec_data,
    output logic        sec_ready,
    input  logic        issue_en,
    input  logic [4:0]  issue_id,
    input  logic [4:0]  rs1_id,
    input  logic [4:0]  rs2_id,
    input  logic [4:0]  rd_id,
    output logic        rs1_busy,
    output logic        rs2_busy,
    output logic        rd_busy,
    output logic        pipe_hold,
    output logic        write_en,
    output logic [4:0]  write_id,
    output logic [31:0] write_data
);

    wb_req_t pri_req;
    wb_req_t sec_req;
    wb_req_t wr;
    logic    sec_grant;

    assign pri_req = '{en: pri_en,    id: pri_id, data: pri_data};
    assign sec_req = '{en: sec_valid, id: sec_id, data: sec_data};

`ifdef WB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] starve_cnt;

    // Count consecutive refused secondary cycles, saturating at the limit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt <= '0;
        end else if (!sec_req.en || sec_grant) begin
            starve_cnt <= '0;
        end else if (starve_cnt != CNT_W'(STARVE_LIMIT)) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

    assign pipe_hold = (starve_cnt == CNT_W'(STARVE_LIMIT));
`else
    assign pipe_hold = 1'b0;
`endif

    // Grant and write-port mux; the x0 destination suppresses the enable only.
    always_comb begin
        sec_grant = 1'b0;
        wr        = '0;
        if (pipe_hold && sec_req.en) begin
            sec_grant = 1'b1;
        end else if (pri_req.en) begin
            sec_grant = 1'b0;
        end else if (sec_req.en) begin
            sec_grant = 1'b1;
        end

        if (sec_grant) begin
            wr    = sec_req;
            wr.en = (sec_req.id != 5'd0);
        end else if (pri_req.en) begin
            wr    = pri_req;
            wr.en = (pri_req.id != 5'd0);
        end
    end

    assign sec_ready  = sec_grant;
    assign write_en   = wr.en;
    assign write_id   = wr.id;
    assign write_data = wr.data;

    regfile_scoreboard u_scoreboard (
        .clk      (clk),
        .reset_n  (reset_n),
        .set_en   (issue_en),
        .set_id   (issue_id),
        .clr_en   (sec_grant),
        .clr_id   (sec_req.id),
        .rs1_id   (rs1_id),
        .rs2_id   (rs2_id),
        .rd_id    (rd_id),
        .rs1_busy (rs1_busy),
        .rs2_busy (rs2_busy),
        .rd_busy  (rd_busy)
    );

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Shares the register file's single write port between the in-order pipeline writeback (primary) and the multi-cycle unit (secondary, loads/MDU) with a valid/ready handshake. Keeps a per-register busy scoreboard for outstanding multi-cycle results so decode can detect read and write-after-write hazards. Sits between the writeback stage, the multi-cycle unit and `register_file`; its write-port outputs drive `register_file` directly.

## Interface
- `STARVE_LIMIT`, 4: consecutive cycles the secondary may be refused before the pipeline is held. Must be ≥ 1.
- `clk` input 1: clock, rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `pri_en` input 1: primary writeback request. It cannot be back-pressured except through `pipe_hold`.
- `pri_id` input 5: primary destination register.
- `pri_data` input 32: primary write data.
- `sec_valid` input 1: secondary result valid.
- `sec_id` input 5: secondary destination register.
- `sec_data` input 32: secondary write data.
- `sec_ready` output 1: secondary result accepted this cycle.
- `issue_en` input 1: a multi-cycle op is issued this cycle.
- `issue_id` input 5: destination register of the issued op.
- `rs1_id` input 5: decode source register 1, checked for hazards.
- `rs2_id` input 5: decode source register 2, checked for hazards.
- `rd_id` input 5: decode destination register, checked for write-after-write (WAW) hazards.
- `rs1_busy` output 1: hazard flag for `rs1_id`.
- `rs2_busy` output 1: hazard flag for `rs2_id`.
- `rd_busy` output 1: hazard flag for `rd_id`.
- `pipe_hold` output 1: freeze the pipeline. The writeback stage re-presents the same `pri_*` next cycle.
- `write_en` output 1: register file write port, write enable.
- `write_id` output 5: register file write port, destination register.
- `write_data` output 32: register file write port, write data.

## Operation
- **Grant, combinational, zero latency.**
  - If `pipe_hold` = 1 and `sec_valid` = 1: the secondary wins.
  - Otherwise, if `pri_en` = 1: the primary wins.
  - Otherwise, if `sec_valid` = 1: the secondary wins.
  - Otherwise: no grant.
  - `sec_ready` = the secondary wins.
  - The write port carries the winner's id and data. With no grant, `write_id`/`write_data` are 0.
- **x0 writes.** A winner with id 0 is still granted and handshaken, but `write_en` is forced to 0.
- **Starvation counter `starve_cnt`**, width `$clog2(STARVE_LIMIT+1)`.
  - Increments when `sec_valid` && !`sec_ready`, saturating at `STARVE_LIMIT`.
  - Clears to 0 on any cycle with `sec_ready` = 1, or with `sec_valid` = 0.
  - `pipe_hold` = (`starve_cnt` == `STARVE_LIMIT`), decoded from the register only.
- **Scoreboard `busy[31:0]`.** `busy[0]` is constantly 0.
  - Set: `issue_en` && `issue_id` != 0 sets `busy[issue_id]`.
  - Clear: a secondary handshake to id k clears `busy[k]`.
  - Same id set and cleared in one cycle: set wins.
  - Issuing to an already-busy id is illegal. Decode prevents it via `rd_busy`, and the bench asserts it never happens.
- **Hazard flags** `rsN_busy`/`rd_busy` = `busy[id]` && !(secondary handshake to that id this cycle). This matches the same-cycle write bypass in `register_file`.
- The primary writing a busy register is a pipeline contract violation, prevented by `rd_busy`. The arbiter does not check it.

## Timing
- **Reset (asynchronous assert, `reset_n` low):** `starve_cnt` = 0 and `busy` = 0. Resulting output values:
  - `pipe_hold` = 0.
  - `rs*_busy` = 0 and `rd_busy` = 0.
  - `write_en` and `sec_ready` follow inputs, and are 0 with idle inputs.
- Reset mid-operation discards all pending busy state. Outstanding multi-cycle ops must be flushed by their owner.
- **Write latency:** the port is driven in the same cycle as the grant. The register file updates on the next `clk` edge.
- **Starvation sequence:**
  - With the primary writing every cycle and the secondary valid, `pipe_hold` rises `STARVE_LIMIT` cycles after `sec_valid` first rises.
  - In the `pipe_hold` cycle the secondary is granted.
  - Next cycle `starve_cnt` = 0, `pipe_hold` = 0, and the primary's retried write is granted.
- **Handshake rule:** once `sec_valid` rises it holds, with stable `sec_id`/`sec_data`, until `sec_ready`.

## Configuration
- `WB_STARVE_GUARD_EN` defined: starvation counter and `pipe_hold` exist as described above.
- `WB_STARVE_GUARD_EN` undefined:
  - No counter; `pipe_hold` is tied to 0.
  - The secondary is granted only in cycles with `pri_en` = 0.
  - All other behaviour is unchanged.

## Structure
- `common` package gains:
  - `wb_req_t` struct: {`en`, `id[4:0]`, `data[31:0]`}, used for both requesters and the write port.
  - Constant `WB_STARVE_LIMIT_DEFAULT` = 4.
- `common` already provides `REGISTER_FILE_SIZE`, which sizes `busy`.
- One sub-module, `regfile_scoreboard`: busy vector, set/clear logic and the three hazard lookups. The grant logic and starvation counter stay in the top module.

## Test plan
- Primary-only traffic `pri_en`=1, `pri_id`=5, `pri_data`=0xDEADBEEF → `write_en`=1, `write_id`=5 in the same cycle; `sec_ready`=0.
- Secondary-only traffic `sec_valid`=1, `sec_id`=7, `sec_data`=0x12345678 after `issue_en`/`issue_id`=7 → `rs1_busy` (rs1_id=7) is 1 from the issue until the handshake, 0 in the handshake cycle, and 0 afterwards.
- Continuous `pri_en`=1 with `sec_valid`=1, `STARVE_LIMIT`=4 (guard enabled) → `pipe_hold`=1 in cycle 4, secondary written that cycle, `pipe_hold`=0 in cycle 5. With the guard disabled, the secondary is never granted.
- Writes to x0 from either requester → `write_en`=0; a secondary x0 write still sees `sec_ready`=1; `busy[0]` stays 0.
- Same-cycle `issue_id`=9 and secondary handshake to 9 → `busy[9]`=1 next cycle.
- `reset_n` pulsed low mid-sequence with `busy[3]`=1 and `starve_cnt`=2 → `busy`=0 and `pipe_hold`=0 immediately, without waiting for `clk`.
